// File: rtl/mul4_arb_pkg.sv
// Shared widths and FSM encoding for the two-requester 4x4 multiplier arbiter.
package mul4_arb_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned P_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mul4x4.sv
// Combinational unsigned 4x4 array multiplier built from ripple full-adder rows.
module mul4x4
  import mul4_arb_pkg::*;
(
  input  logic [OP_W-1:0] m_i,
  input  logic [OP_W-1:0] q_i,
  output logic [P_W-1:0]  p_o
);

  logic [OP_W:0] acc0;

  assign acc0 = {1'b0, m_i & {OP_W{q_i[0]}}};

  // Each row adds the next shifted partial product to the upper bits of the previous row;
  // the row's LSB retires as one product bit.
  for (genvar i = 1; i < OP_W; i++) begin : g_row
    logic [OP_W-1:0] acc_in;
    logic [OP_W-1:0] pp;
    logic [OP_W-1:0] sum;
    logic [OP_W:0]   acc;

    if (i == 1) begin : g_first
      assign acc_in = acc0[OP_W:1];
    end else begin : g_next
      assign acc_in = g_row[i-1].acc[OP_W:1];
    end

    assign pp = m_i & {OP_W{q_i[i]}};

    for (genvar j = 0; j < OP_W; j++) begin : g_fa
      logic a, b, ci, co;
      assign a = acc_in[j];
      assign b = pp[j];
      if (j == 0) begin : g_c0
        assign ci = 1'b0;
      end else begin : g_cn
        assign ci = g_fa[j-1].co;
      end
      assign sum[j] = a ^ b ^ ci;
      assign co     = (a & b) | (ci & (a ^ b));
    end

    assign acc = {g_fa[OP_W-1].co, sum};
  end

  assign p_o = {g_row[3].acc, g_row[2].acc[0], g_row[1].acc[0], acc0[0]};

endmodule

// File: rtl/mul4_rr_arbiter.sv
// Two-requester arbiter in front of a shared 4x4 multiplier: accept, compute, respond.
module mul4_rr_arbiter
  import mul4_arb_pkg::*;
#(
  parameter int unsigned FAIR_RR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_m,
  input  logic [OP_W-1:0] req0_q,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_m,
  input  logic [OP_W-1:0] req1_q,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [P_W-1:0]  rsp0_p,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [P_W-1:0]  rsp1_p,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] m_q, m_d, q_q, q_d;
  logic [P_W-1:0]  prod_q, prod_d, mul_p;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            winner;

  // Returns the requester ID to grant; on a tie, round-robin favours the one not last served.
  function automatic logic pick_winner(input logic v0, input logic v1, input logic last,
                                       input logic fair);
    if (v0 && v1) return fair ? ~last : 1'b0;
    return v1;
  endfunction

  assign winner = pick_winner(req0_valid, req1_valid, last_q, FAIR_RR != 0);

  mul4x4 u_mul (
    .m_i (m_q),
    .q_i (q_q),
    .p_o (mul_p)
  );

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    prod_d     = prod_q;
    owner_d    = owner_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_p     = '0;
    rsp1_p     = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so no handshake is ever advertised while in reset.
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = ~winner;
          req1_ready = winner;
          m_d        = winner ? req1_m : req0_m;
          q_d        = winner ? req1_q : req0_q;
          owner_d    = winner;
          state_d    = CALC;
        end
      end
      CALC: begin
        prod_d  = mul_p;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q) rsp1_p = prod_q;
        else         rsp0_p = prod_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
          if (FAIR_RR != 0) last_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      prod_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      prod_q  <= prod_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mul4_rr_arbiter.sv
// Directed bench for mul4_rr_arbiter: a round-robin and a fixed-priority instance, scoreboarded.
module tb_mul4_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rr_req0_valid, rr_req0_ready, rr_req1_valid, rr_req1_ready;
  logic [3:0] rr_req0_m, rr_req0_q, rr_req1_m, rr_req1_q;
  logic       rr_rsp0_valid, rr_rsp0_ready, rr_rsp1_valid, rr_rsp1_ready, rr_busy;
  logic [7:0] rr_rsp0_p, rr_rsp1_p;

  logic       fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
  logic [3:0] fp_req0_m, fp_req0_q, fp_req1_m, fp_req1_q;
  logic       fp_rsp0_valid, fp_rsp0_ready, fp_rsp1_valid, fp_rsp1_ready, fp_busy;
  logic [7:0] fp_rsp0_p, fp_rsp1_p;

  mul4_rr_arbiter #(.FAIR_RR(1)) dut_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (rr_req0_valid),
    .req0_ready (rr_req0_ready),
    .req0_m     (rr_req0_m),
    .req0_q     (rr_req0_q),
    .req1_valid (rr_req1_valid),
    .req1_ready (rr_req1_ready),
    .req1_m     (rr_req1_m),
    .req1_q     (rr_req1_q),
    .rsp0_valid (rr_rsp0_valid),
    .rsp0_ready (rr_rsp0_ready),
    .rsp0_p     (rr_rsp0_p),
    .rsp1_valid (rr_rsp1_valid),
    .rsp1_ready (rr_rsp1_ready),
    .rsp1_p     (rr_rsp1_p),
    .busy       (rr_busy)
  );

  mul4_rr_arbiter #(.FAIR_RR(0)) dut_fp (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (fp_req0_valid),
    .req0_ready (fp_req0_ready),
    .req0_m     (fp_req0_m),
    .req0_q     (fp_req0_q),
    .req1_valid (fp_req1_valid),
    .req1_ready (fp_req1_ready),
    .req1_m     (fp_req1_m),
    .req1_q     (fp_req1_q),
    .rsp0_valid (fp_rsp0_valid),
    .rsp0_ready (fp_rsp0_ready),
    .rsp0_p     (fp_rsp0_p),
    .rsp1_valid (fp_rsp1_valid),
    .rsp1_ready (fp_rsp1_ready),
    .rsp1_p     (fp_rsp1_p),
    .busy       (fp_busy)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] p;
  } exp_t;

  exp_t sb_rr[$];
  exp_t sb_fp[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_rsp_rr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic fp, input logic id, input logic [7:0] p);
    exp_t e;
    e.id = id;
    e.p  = p;
    if (fp) sb_fp.push_back(e);
    else    sb_rr.push_back(e);
  endtask

  task automatic pop(input logic fp, input logic id, input logic [7:0] p);
    exp_t e;
    int   sz;
    sz = fp ? sb_fp.size() : sb_rr.size();
    check(fp ? "fp_rsp_expected" : "rr_rsp_expected", 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = fp ? sb_fp.pop_front() : sb_rr.pop_front();
      check(fp ? "fp_rsp_id" : "rr_rsp_id", 32'(id), 32'(e.id));
      check(fp ? "fp_rsp_p" : "rr_rsp_p", 32'(p), 32'(e.p));
    end
  endtask

  // Response monitors: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rr_rsp0_valid && rr_rsp0_ready) begin n_rsp_rr++; pop(1'b0, 1'b0, rr_rsp0_p); end
      if (rr_rsp1_valid && rr_rsp1_ready) begin n_rsp_rr++; pop(1'b0, 1'b1, rr_rsp1_p); end
      if (fp_rsp0_valid && fp_rsp0_ready) pop(1'b1, 1'b0, fp_rsp0_p);
      if (fp_rsp1_valid && fp_rsp1_ready) pop(1'b1, 1'b1, fp_rsp1_p);
    end
  end

  task automatic drain(input string tag);
    int w = 0;
    while ((sb_rr.size() != 0 || sb_fp.size() != 0) && w < 12) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(sb_rr.size() + sb_fp.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [3:0] tab_m0 [4] = '{4'd3, 4'd2, 4'd15, 4'd6};
  logic [3:0] tab_q0 [4] = '{4'd5, 4'd11, 4'd4, 4'd6};
  logic [3:0] tab_m1 [4] = '{4'd7, 4'd13, 4'd1, 4'd10};
  logic [3:0] tab_q1 [4] = '{4'd9, 4'd13, 4'd14, 4'd3};

  initial begin
    int   idx0, idx1, fidx, cnt;
    logic got;
    logic exp_id;

    // Reset with both requesters valid: nothing may be advertised.
    rst_n = 1'b0;
    rr_req0_valid = 1'b1; rr_req0_m = 4'd1; rr_req0_q = 4'd1;
    rr_req1_valid = 1'b1; rr_req1_m = 4'd2; rr_req1_q = 4'd2;
    fp_req0_valid = 1'b1; fp_req0_m = 4'd1; fp_req0_q = 4'd1;
    fp_req1_valid = 1'b1; fp_req1_m = 4'd2; fp_req1_q = 4'd2;
    rr_rsp0_ready = 1'b1; rr_rsp1_ready = 1'b1;
    fp_rsp0_ready = 1'b1; fp_rsp1_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_rr_ready", {rr_req1_ready, rr_req0_ready}, 2'b00);
    check("rst_rr_rsp_valid", {rr_rsp1_valid, rr_rsp0_valid}, 2'b00);
    check("rst_rr_busy", rr_busy, 1'b0);
    check("rst_rr_p", {rr_rsp1_p, rr_rsp0_p}, 16'h0);
    check("rst_fp_ready", {fp_req1_ready, fp_req0_ready}, 2'b00);
    check("rst_fp_busy", fp_busy, 1'b0);

    // Tie, both instances: round-robin alternates 0,1,0,1; fixed priority always grants 0.
    tick();
    rst_n = 1'b1;
    idx0 = 0; idx1 = 0; fidx = 0;
    rr_req0_m = tab_m0[0]; rr_req0_q = tab_q0[0]; rr_req1_m = tab_m1[0]; rr_req1_q = tab_q1[0];
    fp_req0_m = tab_m0[0]; fp_req0_q = tab_q0[0]; fp_req1_m = tab_m1[0]; fp_req1_q = tab_q1[0];
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        got = rr_req0_ready | rr_req1_ready;
        check("fp_req1_ready_low", fp_req1_ready, 1'b0);
      end
      check("rr_grant_seen", got, 1'b1);
      exp_id = k[0];
      check("rr_grant", {rr_req1_ready, rr_req0_ready}, exp_id ? 2'b10 : 2'b01);
      check("fp_grant", {fp_req1_ready, fp_req0_ready}, 2'b01);
      if (exp_id) push(1'b0, 1'b1, 8'(rr_req1_m * rr_req1_q));
      else        push(1'b0, 1'b0, 8'(rr_req0_m * rr_req0_q));
      push(1'b1, 1'b0, 8'(fp_req0_m * fp_req0_q));
      tick();
      if (exp_id) begin
        idx1 = (idx1 + 1) % 4;
        rr_req1_m = tab_m1[idx1]; rr_req1_q = tab_q1[idx1];
      end else begin
        idx0 = (idx0 + 1) % 4;
        rr_req0_m = tab_m0[idx0]; rr_req0_q = tab_q0[idx0];
      end
      fidx = (fidx + 1) % 4;
      fp_req0_m = tab_m0[fidx]; fp_req0_q = tab_q0[fidx];
    end
    rr_req0_valid = 1'b0; rr_req1_valid = 1'b0;
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
    drain("tie_drain");

    // Backpressure on requester 1 for five RESP cycles with requester 0 waiting.
    tick();
    rr_rsp1_ready = 1'b0;
    rr_req1_valid = 1'b1; rr_req1_m = 4'd12; rr_req1_q = 4'd10;
    @(negedge clk);
    check("bp_req1_ready", {rr_req1_ready, rr_req0_ready}, 2'b10);
    push(1'b0, 1'b1, 8'h78);
    tick();
    rr_req1_valid = 1'b0;
    rr_req0_valid = 1'b1; rr_req0_m = 4'd1; rr_req0_q = 4'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp1_valid", rr_rsp1_valid, 1'b1);
      check("bp_rsp1_p", rr_rsp1_p, 8'h78);
      check("bp_req0_ready", rr_req0_ready, 1'b0);
      check("bp_rsp0_valid", rr_rsp0_valid, 1'b0);
      tick();
    end
    cnt = n_rsp_rr;
    rr_req0_valid = 1'b0;
    rr_rsp1_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("bp_one_rsp", 32'(n_rsp_rr - cnt), 32'd1);
    check("bp_rsp1_done", rr_rsp1_valid, 1'b0);
    drain("bp_drain");

    // Single request 15*15: latency and busy window.
    tick();
    rr_req0_valid = 1'b1; rr_req0_m = 4'd15; rr_req0_q = 4'd15;
    @(negedge clk);
    check("lat_ready", {rr_req1_ready, rr_req0_ready}, 2'b01);
    check("lat_busy_idle", rr_busy, 1'b0);
    push(1'b0, 1'b0, 8'hE1);
    tick();
    rr_req0_valid = 1'b0;
    @(negedge clk);
    check("lat_busy_t1", rr_busy, 1'b1);
    check("lat_no_early_valid", rr_rsp0_valid, 1'b0);
    check("lat_no_early_p", rr_rsp0_p, 8'h00);
    tick();
    @(negedge clk);
    check("lat_busy_t2", rr_busy, 1'b1);
    check("lat_rsp0_valid", rr_rsp0_valid, 1'b1);
    check("lat_rsp0_p", rr_rsp0_p, 8'hE1);
    check("lat_rsp1_p", {rr_rsp1_valid, rr_rsp1_p}, 9'h0);
    tick();
    @(negedge clk);
    check("lat_busy_end", rr_busy, 1'b0);
    check("lat_rsp0_end", rr_rsp0_valid, 1'b0);

    // Reset in CALC: transaction vanishes and the next tie goes to requester 0.
    tick();
    rr_req0_valid = 1'b1; rr_req0_m = 4'd5; rr_req0_q = 4'd6;
    @(negedge clk);
    check("rstcalc_ready", rr_req0_ready, 1'b1);
    tick();
    rr_req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstcalc_no_rsp", {rr_rsp1_valid, rr_rsp0_valid}, 2'b00);
      check("rstcalc_busy", rr_busy, 1'b0);
      tick();
    end
    rr_req0_valid = 1'b1; rr_req0_m = 4'd2; rr_req0_q = 4'd3;
    rr_req1_valid = 1'b1; rr_req1_m = 4'd4; rr_req1_q = 4'd4;
    @(negedge clk);
    check("rstcalc_tie", {rr_req1_ready, rr_req0_ready}, 2'b01);
    push(1'b0, 1'b0, 8'd6);
    tick();
    rr_req0_valid = 1'b0; rr_req1_valid = 1'b0;
    drain("rstcalc_drain");

    // Exhaustive operand sweep through requester 0.
    tick();
    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        rr_req0_m = 4'(m); rr_req0_q = 4'(q); rr_req0_valid = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 8 && !got; w++) begin
          @(negedge clk);
          got = rr_req0_ready;
        end
        check("sweep_ready", got, 1'b1);
        push(1'b0, 1'b0, 8'(m * q));
        tick();
        rr_req0_valid = 1'b0;
      end
    end
    drain("sweep_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
